// File: rtl/regbank_ctrl_if.sv
// Host-side command/response channel of regbank_ctrl.
//   master : the host (issues commands, accepts read responses)
//   slave  : regbank_ctrl
// Command: cmd_valid/cmd_ready handshake carrying cmd_op, cmd_addr_a, cmd_addr_b,
//          cmd_len (FILL count minus 1) and cmd_data.
// Response: rsp_valid/rsp_ready handshake carrying rsp_data1/rsp_data2.
interface regbank_ctrl_if #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 32
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr_a;
   logic [AW-1:0] cmd_addr_b;
   logic [AW-1:0] cmd_len;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data1;
   logic [DW-1:0] rsp_data2;

   modport master (
      output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_len, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data1, rsp_data2
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_len, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data1, rsp_data2
   );
endinterface

// File: rtl/regbank_ctrl.sv
// Requester-side controller for a combinational-read, posedge-write register bank.
// Accepts WRITE / READ / READ2 / FILL commands from the host and drives the bank's
// write port and both read ports; read data comes back on the response channel.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   host           command/response channel (regbank_ctrl_if.slave)
//   busy_o         high whenever the controller is not idle
//   rb_dr_o, rb_wrdata_o, rb_write_o    bank write port (registered)
//   rb_sr1_o, rb_sr2_o                  bank read addresses (registered)
//   rb_rddata1_i, rb_rddata2_i          bank read data (combinational)
module regbank_ctrl #(
   parameter bit          FILL_INC = 1'b0,
   parameter int unsigned AW       = 5,
   parameter int unsigned DW       = 32
) (
   input  logic          clk,
   input  logic          rst,
   regbank_ctrl_if.slave host,
   output logic          busy_o,
   output logic [AW-1:0] rb_dr_o,
   output logic [DW-1:0] rb_wrdata_o,
   output logic          rb_write_o,
   output logic [AW-1:0] rb_sr1_o,
   output logic [AW-1:0] rb_sr2_o,
   input  logic [DW-1:0] rb_rddata1_i,
   input  logic [DW-1:0] rb_rddata2_i
);

   typedef enum logic [2:0] {StIdle, StWr, StFill, StRd, StResp} state_e;

   localparam logic [1:0]    OpWrite  = 2'b00;
   localparam logic [1:0]    OpRead   = 2'b01;
   localparam logic [1:0]    OpRead2  = 2'b10;
   localparam logic [1:0]    OpFill   = 2'b11;
   localparam logic [DW-1:0] FillStep = {{(DW-1){1'b0}}, FILL_INC};

   state_e        state_q, state_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          write_q, write_d;
   logic [AW-1:0] dr_q, dr_d;
   logic [DW-1:0] wrdata_q, wrdata_d;
   logic [AW-1:0] sr1_q, sr1_d;
   logic [AW-1:0] sr2_q, sr2_d;
   logic [AW-1:0] cnt_q, cnt_d;      // FILL writes remaining after the current one
   logic [DW-1:0] rsp1_q, rsp1_d;
   logic [DW-1:0] rsp2_q, rsp2_d;

   always_comb begin
      state_d  = state_q;
      write_d  = 1'b0;
      dr_d     = dr_q;
      wrdata_d = wrdata_q;
      sr1_d    = sr1_q;
      sr2_d    = sr2_q;
      cnt_d    = cnt_q;
      rsp1_d   = rsp1_q;
      rsp2_d   = rsp2_q;

      case (state_q)
         StIdle: begin
            if (host.cmd_valid && cmd_ready_q) begin
               case (host.cmd_op)
                  OpWrite: begin
                     state_d  = StWr;
                     write_d  = 1'b1;
                     dr_d     = host.cmd_addr_a;
                     wrdata_d = host.cmd_data;
                  end
                  OpFill: begin
                     state_d  = StFill;
                     write_d  = 1'b1;
                     dr_d     = host.cmd_addr_a;
                     wrdata_d = host.cmd_data;
                     cnt_d    = host.cmd_len;
                  end
                  OpRead, OpRead2: begin
                     state_d = StRd;
                     sr1_d   = host.cmd_addr_a;
                     sr2_d   = (host.cmd_op == OpRead2) ? host.cmd_addr_b : host.cmd_addr_a;
                  end
                  default: state_d = StIdle;
               endcase
            end
         end
         StWr: state_d = StIdle;
         StFill: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               // Address wraps naturally at 2^AW.
               write_d  = 1'b1;
               dr_d     = dr_q + 1'b1;
               wrdata_d = wrdata_q + FillStep;
               cnt_d    = cnt_q - 1'b1;
            end
         end
         StRd: begin
            rsp1_d  = rb_rddata1_i;
            rsp2_d  = rb_rddata2_i;
            state_d = StResp;
         end
         StResp: begin
            if (host.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Registered so it stays low during reset and rises on the first edge after.
      cmd_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b0;
         write_q     <= 1'b0;
         dr_q        <= '0;
         wrdata_q    <= '0;
         sr1_q       <= '0;
         sr2_q       <= '0;
         cnt_q       <= '0;
         rsp1_q      <= '0;
         rsp2_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         write_q     <= write_d;
         dr_q        <= dr_d;
         wrdata_q    <= wrdata_d;
         sr1_q       <= sr1_d;
         sr2_q       <= sr2_d;
         cnt_q       <= cnt_d;
         rsp1_q      <= rsp1_d;
         rsp2_q      <= rsp2_d;
      end
   end

   assign host.cmd_ready = cmd_ready_q;
   assign host.rsp_valid = (state_q == StResp);
   assign host.rsp_data1 = rsp1_q;
   assign host.rsp_data2 = rsp2_q;
   assign busy_o         = (state_q != StIdle);
   assign rb_dr_o        = dr_q;
   assign rb_wrdata_o    = wrdata_q;
   assign rb_write_o     = write_q;
   assign rb_sr1_o       = sr1_q;
   assign rb_sr2_o       = sr2_q;

endmodule

// File: tb/tb_regbank_ctrl.sv
// Bench for regbank_ctrl: two instances (FILL_INC=1 as inst0, FILL_INC=0 as inst1) see the
// same command stream, each with its own bank. Expected bank contents come from a plain
// array model updated with the command's arithmetic meaning.
module tb_regbank_ctrl;

   localparam logic [1:0] OpWrite = 2'b00;
   localparam logic [1:0] OpRead  = 2'b01;
   localparam logic [1:0] OpRead2 = 2'b10;
   localparam logic [1:0] OpFill  = 2'b11;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_a, cmd_b, cmd_len;
   logic [31:0] cmd_data;
   logic        rsp_ready;

   logic        obs_ready [2];
   logic        obs_valid [2];
   logic        obs_write [2];
   logic        obs_busy  [2];
   logic [4:0]  obs_dr    [2];
   logic [4:0]  obs_sr1   [2];
   logic [4:0]  obs_sr2   [2];
   logic [31:0] obs_wd    [2];
   logic [31:0] obs_d1    [2];
   logic [31:0] obs_d2    [2];

   logic [31:0] ref_mem [2][32];
   logic [31:0] got1 [2];
   logic [31:0] got2 [2];

   int          wtot [2];
   int          btot [2];
   logic [4:0]  wadr [2][256];
   logic [31:0] wdat [2][256];

   int n_pass;
   int n_total;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      regbank_ctrl_if #(.AW(5), .DW(32)) bus ();
      logic        we, busy;
      logic [4:0]  dr, sr1, sr2;
      logic [31:0] wd, rd1, rd2;
      logic [31:0] mem [32];

      regbank_ctrl #(.FILL_INC(k == 0), .AW(5), .DW(32)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .host         (bus),
         .busy_o       (busy),
         .rb_dr_o      (dr),
         .rb_wrdata_o  (wd),
         .rb_write_o   (we),
         .rb_sr1_o     (sr1),
         .rb_sr2_o     (sr2),
         .rb_rddata1_i (rd1),
         .rb_rddata2_i (rd2)
      );

      assign bus.cmd_valid  = cmd_valid;
      assign bus.cmd_op     = cmd_op;
      assign bus.cmd_addr_a = cmd_a;
      assign bus.cmd_addr_b = cmd_b;
      assign bus.cmd_len    = cmd_len;
      assign bus.cmd_data   = cmd_data;
      assign bus.rsp_ready  = rsp_ready;

      always @(posedge clk) if (we) mem[dr] <= wd;
      assign rd1 = mem[sr1];
      assign rd2 = mem[sr2];

      assign obs_ready[k] = bus.cmd_ready;
      assign obs_valid[k] = bus.rsp_valid;
      assign obs_d1[k]    = bus.rsp_data1;
      assign obs_d2[k]    = bus.rsp_data2;
      assign obs_write[k] = we;
      assign obs_busy[k]  = busy;
      assign obs_dr[k]    = dr;
      assign obs_sr1[k]   = sr1;
      assign obs_sr2[k]   = sr2;
      assign obs_wd[k]    = wd;
   end

   // Log of bank writes actually committed, and count of busy cycles.
   initial begin
      for (int k = 0; k < 2; k++) begin
         wtot[k] = 0;
         btot[k] = 0;
      end
   end
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (obs_write[k]) begin
            wadr[k][wtot[k][7:0]] <= obs_dr[k];
            wdat[k][wtot[k][7:0]] <= obs_wd[k];
            wtot[k] <= wtot[k] + 1;
         end
         if (obs_busy[k]) btot[k] <= btot[k] + 1;
      end
   end

   // Reference: writes len+1 registers from a, wrapping; inst0 increments the data.
   function automatic void model_fill(input logic [4:0] a, input logic [4:0] len,
                                      input logic [31:0] d);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i <= int'(len); i++)
            ref_mem[k][(int'(a) + i) % 32] = d + ((k == 0) ? 32'(i) : 32'd0);
   endfunction

   task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] len, input logic [31:0] d);
      int t;
      t = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_len   = len;
      cmd_data  = d;
      while (!obs_ready[0] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_total++;
         $display("FAIL issue_timeout: cmd_ready=%b want 1", obs_ready[0]);
      end
      @(posedge clk);
      #1;
      // Garbage after acceptance must not disturb the command in progress.
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_a     = 5'($urandom);
      cmd_b     = 5'($urandom);
      cmd_len   = 5'($urandom);
      cmd_data  = $urandom;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (obs_busy[0] && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         n_total++;
         $display("FAIL idle_timeout: busy=%b want 0", obs_busy[0]);
      end
   endtask

   task automatic collect(input int stall);
      int t;
      t = 0;
      rsp_ready = 1'b0;
      @(negedge clk);
      while (!obs_valid[0] && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) begin
         n_total++;
         $display("FAIL rsp_timeout: rsp_valid=%b want 1", obs_valid[0]);
      end
      for (int k = 0; k < 2; k++) begin
         got1[k] = obs_d1[k];
         got2[k] = obs_d2[k];
      end
      repeat (stall) @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if ({obs_write[k], obs_dr[k], obs_wd[k], obs_sr1[k], obs_sr2[k]} !== '0)
            $display("FAIL reset_bank inst%0d: got we=%b dr=%h wd=%h sr1=%h sr2=%h want 0",
                     k, obs_write[k], obs_dr[k], obs_wd[k], obs_sr1[k], obs_sr2[k]);
         else n_pass++;
         n_total++;
         if ({obs_valid[k], obs_d1[k], obs_d2[k], obs_busy[k], obs_ready[k]} !== '0)
            $display("FAIL reset_host inst%0d: got v=%b d1=%h d2=%h busy=%b rdy=%b want 0",
                     k, obs_valid[k], obs_d1[k], obs_d2[k], obs_busy[k], obs_ready[k]);
         else n_pass++;
      end
      rst = 1'b0;
      #1;
      n_total++;
      if (obs_ready[0] !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", obs_ready[0]);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (obs_ready[0] !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", obs_ready[0]);
      else n_pass++;
   endtask

   task automatic test_write_read();
      int w0;
      w0 = wtot[0];
      issue(OpWrite, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if ({obs_write[k], obs_dr[k], obs_wd[k], obs_ready[k]} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0})
            $display("FAIL wr_cycle inst%0d: got we=%b dr=%0d wd=%h rdy=%b want 1/5/deadbeef/0",
                     k, obs_write[k], obs_dr[k], obs_wd[k], obs_ready[k]);
         else n_pass++;
      end
      @(posedge clk);
      #1;
      n_total++;
      if ({obs_write[0], obs_ready[0]} !== 2'b01)
         $display("FAIL wr_end: got we=%b rdy=%b want 0/1", obs_write[0], obs_ready[0]);
      else n_pass++;
      n_total++;
      if (wtot[0] - w0 !== 1) $display("FAIL wr_count: got %0d want 1", wtot[0] - w0);
      else n_pass++;
      model_fill(5'd5, 5'd0, 32'hDEADBEEF);

      issue(OpRead, 5'd5, 5'd9, 5'd0, 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      n_total++;
      if ({obs_valid[0], obs_sr1[0], obs_sr2[0]} !== {1'b0, 5'd5, 5'd5})
         $display("FAIL rd_cycle: got v=%b sr1=%0d sr2=%0d want 0/5/5",
                  obs_valid[0], obs_sr1[0], obs_sr2[0]);
      else n_pass++;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if ({obs_valid[k], obs_d1[k], obs_d2[k]} !== {1'b1, ref_mem[k][5], ref_mem[k][5]})
            $display("FAIL rd_resp inst%0d: got v=%b d1=%h d2=%h want 1/%h/%h",
                     k, obs_valid[k], obs_d1[k], obs_d2[k], ref_mem[k][5], ref_mem[k][5]);
         else n_pass++;
      end
      @(negedge clk);
      n_total++;
      if (obs_valid[0] !== 1'b0) $display("FAIL rd_latency: got v=%b want 0", obs_valid[0]);
      else n_pass++;
      rsp_ready = 1'b0;
   endtask

   task automatic test_fill(input logic [4:0] a, input logic [4:0] len, input logic [31:0] d,
                            input logic [4:0] ra, input logic [4:0] rb);
      int w0 [2];
      int b0 [2];
      int idx;
      for (int k = 0; k < 2; k++) begin
         w0[k] = wtot[k];
         b0[k] = btot[k];
      end
      issue(OpFill, a, 5'd0, len, d);
      wait_idle();
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (wtot[k] - w0[k] !== int'(len) + 1)
            $display("FAIL fill_count inst%0d: got %0d want %0d", k, wtot[k] - w0[k], len + 1);
         else n_pass++;
         n_total++;
         if (btot[k] - b0[k] !== int'(len) + 1)
            $display("FAIL fill_busy inst%0d: got %0d want %0d", k, btot[k] - b0[k], len + 1);
         else n_pass++;
         for (int i = 0; i <= int'(len); i++) begin
            idx = (w0[k] + i) % 256;
            n_total++;
            if ({wadr[k][idx], wdat[k][idx]} !==
                {5'((int'(a) + i) % 32), d + ((k == 0) ? 32'(i) : 32'd0)})
               $display("FAIL fill_write inst%0d #%0d: got a=%0d d=%h want a=%0d d=%h", k, i,
                        wadr[k][idx], wdat[k][idx], (int'(a) + i) % 32,
                        d + ((k == 0) ? 32'(i) : 32'd0));
            else n_pass++;
         end
      end
      model_fill(a, len, d);
      issue(OpRead2, ra, rb, 5'd0, 32'd0);
      collect(0);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if ({got1[k], got2[k]} !== {ref_mem[k][ra], ref_mem[k][rb]})
            $display("FAIL fill_read inst%0d: got %h/%h want %h/%h", k, got1[k], got2[k],
                     ref_mem[k][ra], ref_mem[k][rb]);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      int w0;
      int hi;
      logic [31:0] s1, s2;
      w0 = wtot[0];
      hi = 0;
      issue(OpRead2, 5'd3, 5'd7, 5'd0, 32'd0);
      rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      s1 = obs_d1[0];
      s2 = obs_d2[0];
      n_total++;
      if ({s1, s2} !== {ref_mem[0][3], ref_mem[0][7]})
         $display("FAIL stall_data: got %h/%h want %h/%h", s1, s2, ref_mem[0][3], ref_mem[0][7]);
      else n_pass++;
      // Host offers a new WRITE while the response is stalled.
      cmd_valid = 1'b1;
      cmd_op    = OpWrite;
      cmd_a     = 5'd3;
      cmd_data  = 32'h0BAD0BAD;
      for (int s = 0; s < 5; s++) begin
         if (obs_valid[0]) hi++;
         n_total++;
         if ({obs_ready[0], obs_d1[0], obs_d2[0]} !== {1'b0, s1, s2})
            $display("FAIL stall_hold cyc%0d: got rdy=%b d=%h/%h want 0/%h/%h", s,
                     obs_ready[0], obs_d1[0], obs_d2[0], s1, s2);
         else n_pass++;
         @(negedge clk);
      end
      if (obs_valid[0]) hi++;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      if (obs_valid[0]) hi++;
      n_total++;
      if (hi !== 6) $display("FAIL stall_valid_cycles: got %0d want 6", hi);
      else n_pass++;
      n_total++;
      if (wtot[0] - w0 !== 0) $display("FAIL stall_no_accept: got %0d writes want 0", wtot[0] - w0);
      else n_pass++;
   endtask

   task automatic release_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_total++;
      if (obs_ready[0] !== 1'b0) $display("FAIL rel_ready_low: got %b want 0", obs_ready[0]);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (obs_ready[0] !== 1'b1) $display("FAIL rel_ready_high: got %b want 1", obs_ready[0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_fill();
      int w0;
      w0 = wtot[0];
      issue(OpFill, 5'd10, 5'd0, 5'd7, 32'h5000);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      n_total++;
      if (obs_write[0] !== 1'b1) $display("FAIL midfill_active: got we=%b want 1", obs_write[0]);
      else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if ({obs_write[k], obs_busy[k], obs_ready[k]} !== 3'b000)
            $display("FAIL midfill_rst inst%0d: got we=%b busy=%b rdy=%b want 0/0/0", k,
                     obs_write[k], obs_busy[k], obs_ready[k]);
         else n_pass++;
      end
      release_reset();
      n_total++;
      if (wtot[0] - w0 !== 2) $display("FAIL midfill_count: got %0d want 2", wtot[0] - w0);
      else n_pass++;
      model_fill(5'd10, 5'd1, 32'h5000);
      for (int r = 10; r < 18; r += 2) begin
         issue(OpRead2, 5'(r), 5'(r + 1), 5'd0, 32'd0);
         collect(1);
         for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({got1[k], got2[k]} !== {ref_mem[k][r], ref_mem[k][r + 1]})
               $display("FAIL midfill_read inst%0d r%0d: got %h/%h want %h/%h", k, r,
                        got1[k], got2[k], ref_mem[k][r], ref_mem[k][r + 1]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_resp();
      issue(OpRead, 5'd5, 5'd0, 5'd0, 32'd0);
      rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++;
      if ({obs_valid[0], obs_d1[0], obs_d2[0]} !== '0)
         $display("FAIL midresp_rst: got v=%b d=%h/%h want 0", obs_valid[0], obs_d1[0], obs_d2[0]);
      else n_pass++;
      release_reset();
   endtask

   task automatic test_back_to_back();
      logic [1:0]  ops [3];
      logic [31:0] dat [3];
      int acc [3];
      int n;
      logic took;
      ops[0] = OpWrite; ops[1] = OpWrite; ops[2] = OpRead;
      dat[0] = 32'd1;   dat[1] = 32'd2;   dat[2] = 32'd0;
      n = 0;
      @(negedge clk);
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_a     = 5'd9;
      cmd_op    = ops[0];
      cmd_data  = dat[0];
      for (int c = 0; c < 12 && n < 3; c++) begin
         took = obs_ready[0];
         if (took) begin
            acc[n] = c;
            if (ops[n] == OpWrite) model_fill(5'd9, 5'd0, dat[n]);
            n++;
         end
         @(posedge clk);
         #1;
         if (took) begin
            if (n < 3) begin
               cmd_op   = ops[n];
               cmd_data = dat[n];
            end else begin
               cmd_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      n_total++;
      if (n !== 3 || acc[0] !== 0 || acc[1] !== 2 || acc[2] !== 4)
         $display("FAIL b2b_accept: got n=%0d cycles %0d,%0d,%0d want 3 cycles 0,2,4",
                  n, acc[0], acc[1], acc[2]);
      else n_pass++;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if ({obs_valid[k], obs_d1[k], obs_d2[k]} !== {1'b1, ref_mem[k][9], ref_mem[k][9]})
            $display("FAIL b2b_resp inst%0d: got v=%b d=%h/%h want 1/%h/%h", k,
                     obs_valid[k], obs_d1[k], obs_d2[k], ref_mem[k][9], ref_mem[k][9]);
         else n_pass++;
      end
      n_total++;
      if (obs_d1[0] !== 32'd2) $display("FAIL b2b_value: got %h want 2", obs_d1[0]);
      else n_pass++;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [4:0]  a, b, len;
      logic [31:0] d;
      int w0 [2];
      int expw;
      for (int n = 0; n < 40; n++) begin
         op  = 2'($urandom);
         a   = 5'($urandom);
         b   = 5'($urandom);
         len = 5'($urandom_range(0, 7));
         d   = $urandom;
         for (int k = 0; k < 2; k++) w0[k] = wtot[k];
         issue(op, a, b, len, d);
         if (op == OpWrite || op == OpFill) begin
            wait_idle();
            expw = (op == OpFill) ? int'(len) + 1 : 1;
            for (int k = 0; k < 2; k++) begin
               n_total++;
               if (wtot[k] - w0[k] !== expw)
                  $display("FAIL rand_writes inst%0d op%0d: got %0d want %0d", k, op,
                           wtot[k] - w0[k], expw);
               else n_pass++;
            end
            model_fill(a, (op == OpFill) ? len : 5'd0, d);
         end else begin
            collect(int'($urandom_range(0, 3)));
            for (int k = 0; k < 2; k++) begin
               n_total++;
               if ({got1[k], got2[k]} !== {ref_mem[k][a], ref_mem[k][(op == OpRead2) ? b : a]})
                  $display("FAIL rand_read inst%0d a=%0d b=%0d: got %h/%h want %h/%h", k, a, b,
                           got1[k], got2[k], ref_mem[k][a], ref_mem[k][(op == OpRead2) ? b : a]);
               else n_pass++;
            end
         end
      end
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_a     = 5'd0;
      cmd_b     = 5'd0;
      cmd_len   = 5'd0;
      cmd_data  = 32'd0;
      rsp_ready = 1'b0;

      test_reset();
      test_write_read();
      test_fill(5'd30, 5'd3, 32'h100, 5'd31, 5'd1);
      test_fill(5'd0, 5'd31, 32'hA5A5A5A5, 5'd0, 5'd31);
      test_stall();
      test_reset_mid_fill();
      test_reset_mid_resp();
      test_back_to_back();
      test_random();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regbank_ctrl.md
Name: regbank_ctrl

Overview:
Requester-side controller that drives the 32x32 register bank's write port (dr/wrdata/write) and both read ports (sr1/sr2), and returns read data.
- Host side: valid/ready command channel and valid/ready response channel.
- Bank side: a combinational-read, posedge-write bank on the same clock.
- Commands: single write, single/dual read, and multi-register FILL (used for bank initialisation and test patterns).

Parameters:
- FILL_INC, 0: if 1, FILL data increments by 1 (mod 2^32) per register written; if 0, FILL data is constant.
- AW, 5: register address width; bank depth is 2^AW.
- DW, 32: data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept; high only in IDLE
- cmd_op  in  2  00 WRITE, 01 READ, 10 READ2, 11 FILL
- cmd_addr_a  in  AW  write/fill start address, or read address 1
- cmd_addr_b  in  AW  read address 2 (READ2 only)
- cmd_len  in  AW  FILL count minus 1
- cmd_data  in  DW  write/fill data
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  host accepts response
- rsp_data1  out  DW  data at addr_a
- rsp_data2  out  DW  data at addr_b (READ2); equals rsp_data1 for READ
- busy  out  1  high in any state other than IDLE
- rb_dr  out  AW  bank write address
- rb_wrdata  out  DW  bank write data
- rb_write  out  1  bank write enable
- rb_sr1  out  AW  bank read address 1
- rb_sr2  out  AW  bank read address 2
- rb_rddata1  in  DW  bank read data 1 (combinational)
- rb_rddata2  in  DW  bank read data 2 (combinational)

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - These outputs are 0: rb_write, rb_dr, rb_wrdata, rb_sr1, rb_sr2, rsp_valid, rsp_data1, rsp_data2, busy.
  - cmd_ready is 0 while rst is high and 1 from the first clock edge after release.
- States are IDLE, WR, FILL, RD, RESP. All bank-side outputs are registered.
- IDLE: cmd_ready=1. A command is accepted on a posedge where cmd_valid && cmd_ready. Operands are latched on that edge.
  - WRITE goes to WR.
  - READ/READ2 go to RD.
  - FILL goes to FILL.
- WR: exactly one cycle with rb_write=1, rb_dr=addr_a, rb_wrdata=data; then IDLE.
  - Write throughput is one command per 2 cycles.
- FILL: writes len+1 registers starting at addr_a, one per cycle, with rb_write=1 every cycle.
  - Address increments mod 2^AW, so writes wrap past 31 to 0.
  - Data is constant, or +1 per register if FILL_INC=1.
  - len=31 writes all 32 registers exactly once.
  - Leaves to IDLE after the last write; rb_write=0 from that point.
- RD: rb_sr1=addr_a; rb_sr2=addr_b for READ2, addr_a for READ. Both are valid for the whole RD cycle.
  - rb_rddata1/2 are captured into rsp_data1/2 on the edge ending RD; state then goes to RESP.
- RESP: rsp_valid=1. rsp_data1/2 are held stable until rsp_valid && rsp_ready on an edge; then rsp_valid=0 and state is IDLE.
  - rsp_ready high on the first RESP edge gives a minimum read latency of 3 cycles from acceptance to rsp_valid falling.
  - rsp_ready asserted outside RESP is ignored.
- rb_write is 0 in every state except WR and FILL.
- Read-after-write ordering: a write completes at the edge ending WR/FILL. Any later accepted READ returns the new value; no bypass logic is needed.
- No overlap between commands: cmd_ready=0 in WR, FILL, RD and RESP; cmd_valid in those states is ignored and the command must be held by the host.
- Reset mid-FILL: writes stop immediately (rb_write=0 asynchronously). Registers already written keep their values, since this block does not drive the bank's reset.
- Reset mid-RESP: rsp_valid drops immediately and the response is discarded.
- cmd_op/addr/data changing after acceptance have no effect on the command in progress.

Test Plan:
- Reset, then WRITE addr 5 data 0xDEADBEEF, then READ addr 5 -> exactly one cycle of rb_write with rb_dr=5; rsp_data1=rsp_data2=0xDEADBEEF; cmd_ready low for 1 cycle after the write is accepted.
- FILL addr 30 len 3 data 0x100 with FILL_INC=1 -> 4 consecutive rb_write cycles at addresses 30,31,0,1 with data 0x100..0x103; READ2 addr 31/1 returns 0x101/0x103.
- FILL addr 0 len 31 data 0xA5A5A5A5 (FILL_INC=0), then READ2 addr 0/31 -> 32 write cycles; both responses 0xA5A5A5A5; busy high for exactly 32 cycles.
- READ2 addr 3/7 with rsp_ready held low for 5 cycles -> rsp_valid high for 6 cycles; rsp_data stable throughout; cmd_ready=0 until handshake; new cmd_valid during the stall is not accepted.
- Assert rst asynchronously mid-FILL (after 2 writes of len 7) -> rb_write=0 before the next edge; only 2 registers modified; cmd_ready=1 one edge after rst release.
- Back-to-back WRITE r9=1, WRITE r9=2, READ r9 with cmd_valid held continuously -> accepts on cycles 0, 2, 4; response 2.
